bist_march_ctrl: RTL and testbench
==================================

Name: bist_march_ctrl

Overview:
- Memory BIST sequencer that runs a March C- test on a single-port RAM.
- Drives the address counter, read/write strobes and data background, and compares read data against the expected value.
- Reports sticky fail and done flags plus failure diagnostics.
- Sits between the top-level BIST start/status interface and the memory under test. It is the sequencing layer above the up/down address counter and the equality comparator.

Parameters:
- ADDR_W, 4, address width; N = 2^ADDR_W words.
- DATA_W, 8, memory word width.
- STOP_ON_FAIL, 1, 1 = abort to DONE on first mismatch; 0 = finish the whole algorithm.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a test when in IDLE or DONE.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re.
- mem_addr  out  ADDR_W  memory address, the counter value.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe.
- mem_wdata  out  DATA_W  write data: all-0 or all-1 background.
- busy  out  1  test in progress.
- done  out  1  sticky; test finished.
- fail  out  1  sticky; at least one mismatch.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_elem  out  3  march element index (0-5) of the first mismatch.

Behaviour:
- Reset: every output is 0. State goes to IDLE, element = 0, counter = 0. rst mid-test aborts immediately with no further memory strobes.
- March C- elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- States: IDLE, RD, CMP, WR, DONE.
- Per address:
  - E0: WR only.
  - E1-E4: RD, CMP, WR (3 cycles).
  - E5: RD, CMP (2 cycles).
- RD: mem_re=1.
- CMP: compare mem_rdata with expected (0 -> {DATA_W{0}}, 1 -> {DATA_W{1}}). No strobes.
- WR: mem_we=1, mem_wdata = element write value.
- Counter control:
  - The counter advances on the last step of each address.
  - At the terminal address (N-1 going up, 0 going down) the element index increments instead.
  - The counter is reset to 0 for up elements and preset to N-1 for down elements.
- Start:
  - Sampled high in IDLE or DONE: clears done, fail, fail_addr and fail_elem; sets busy.
  - The first E0 write occurs on the next cycle.
  - start while busy is ignored.
- Completion: after the final E5 CMP, the next cycle enters DONE with busy=0, done=1. DONE holds until start or rst.
- Total busy cycles for a fault-free run: N + 4*3N + 2N = 15N (240 for N=16).
- Mismatch in CMP:
  - fail=1 on the next cycle.
  - fail_addr and fail_elem capture the current address and element only if fail was 0, so only the first failure is recorded.
  - STOP_ON_FAIL=1: next state is DONE; the WR of that address is suppressed.
  - STOP_ON_FAIL=0: continue normally.
- mem_addr changes only at address boundaries and is stable across the RD/CMP/WR of one address.

Decomposition:
- Package bist_pkg:
  - State enum (IDLE, RD, CMP, WR, DONE).
  - Element index constants E0-E5.
  - Per-element tables: direction, read-expected value, write value, has_read, has_write.
- Sub-module bist_addr_counter:
  - Ports: clk, rst, reset, preset, en, up_down → count, carry.
  - carry = terminal count for the current direction.
- The controller FSM is the parent.

Test Plan:
- Fault-free RAM model, N=16, start pulse at cycle 10 -> busy for exactly 240 cycles, then done=1, fail=0. Address trace: E3 and E4 descend 15..0, all other elements ascend 0..15.
- Bit 2 of addr 5 stuck-at-1, STOP_ON_FAIL=1 -> mismatch in E1 r0: fail=1, fail_addr=5, fail_elem=1, done=1 on the cycle after that CMP; no mem_we at addr 5 in E1.
- Same fault, STOP_ON_FAIL=0 -> full 240-cycle run, fail_addr=5, fail_elem=1 retained despite later mismatches in E3 and E5.
- Assert rst during E2 at addr 7 -> next cycle all outputs 0, no strobes; a later start runs a clean 240-cycle test.
- start pulsed again during E1 -> ignored, run length unchanged. start pulsed in DONE -> flags cleared, new run begins.
- Stuck-at-0 at addr 15 bit 0 -> detected in E2 r1: fail_addr=15, fail_elem=2.

Source files
------------

// File: rtl/bist_pkg.sv
// March C- sequencing tables shared by the BIST controller and its bench-facing types.
// Pure combinational lookups, no state.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CMP,
      ST_WR,
      ST_DONE
   } state_e;

   localparam logic [2:0] E0 = 3'd0;
   localparam logic [2:0] E1 = 3'd1;
   localparam logic [2:0] E2 = 3'd2;
   localparam logic [2:0] E3 = 3'd3;
   localparam logic [2:0] E4 = 3'd4;
   localparam logic [2:0] E5 = 3'd5;

   // E3/E4 walk the array downwards, everything else ascends
   function automatic logic elem_up(input logic [2:0] e);
      return !((e == E3) || (e == E4));
   endfunction

   function automatic logic elem_rd_val(input logic [2:0] e);
      return (e == E2) || (e == E4);
   endfunction

   function automatic logic elem_wr_val(input logic [2:0] e);
      return (e == E1) || (e == E3);
   endfunction

   function automatic logic elem_has_rd(input logic [2:0] e);
      return e != E0;
   endfunction

   function automatic logic elem_has_wr(input logic [2:0] e);
      return e != E5;
   endfunction

endpackage

// File: rtl/bist_march_ctrl_if.sv
// Start/status and memory-side signals of the March C- BIST controller.
// master = controller side, slave = environment (memory + BIST top) side.
interface bist_march_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;
   logic              done;
   logic              fail;
   logic [ADDR_W-1:0] fail_addr;
   logic [2:0]        fail_elem;

   modport master (
      input  start, mem_rdata,
      output mem_addr, mem_re, mem_we, mem_wdata, busy, done, fail, fail_addr, fail_elem
   );

   modport slave (
      output start, mem_rdata,
      input  mem_addr, mem_re, mem_we, mem_wdata, busy, done, fail, fail_addr, fail_elem
   );
endinterface

// File: rtl/bist_addr_counter.sv
// Up/down address counter with synchronous clear/preset; carry flags the terminal count.
// One-cycle update latency, carry is combinational from the current count and direction.
module bist_addr_counter #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reset,
   input  logic              preset,
   input  logic              en,
   input  logic              up_down,
   output logic [ADDR_W-1:0] count,
   output logic              carry
);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (reset) begin
         count_d = '0;
      end else if (preset) begin
         count_d = '1;
      end else if (en) begin
         count_d = up_down ? (count_q + ONE) : (count_q - ONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign carry = up_down ? (count_q == '1) : (count_q == '0);

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- BIST sequencer: walks six elements over a single-port RAM, sticky done/fail, first-fail diagnostics.
// Memory read data is compared one cycle after the read strobe; a fault-free run is busy for 15*N cycles.
module bist_march_ctrl
   import bist_pkg::*;
#(
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 8,
   parameter bit STOP_ON_FAIL = 1'b1
) (
   input logic              clk,
   input logic              rst,
   bist_march_ctrl_if.master bus
);
   state_e            state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]        fail_elem_q, fail_elem_d;

   logic              cnt_reset, cnt_preset, cnt_en;
   logic [ADDR_W-1:0] count;
   logic              carry;
   logic              mem_re, mem_we;
   logic [2:0]        elem_nxt;
   logic [DATA_W-1:0] rd_exp;
   logic              mismatch;

   bist_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .reset   (cnt_reset),
      .preset  (cnt_preset),
      .en      (cnt_en),
      .up_down (elem_up(elem_q)),
      .count   (count),
      .carry   (carry)
   );

   assign elem_nxt = elem_q + 3'd1;
   assign rd_exp   = elem_rd_val(elem_q) ? '1 : '0;
   assign mismatch = (bus.mem_rdata != rd_exp);

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      cnt_reset   = 1'b0;
      cnt_preset  = 1'b0;
      cnt_en      = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d     = ST_WR;
               elem_d      = E0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = '0;
               cnt_reset   = 1'b1;
            end
         end
         ST_RD: begin
            mem_re  = 1'b1;
            state_d = ST_CMP;
         end
         ST_CMP: begin
            if (mismatch) begin
               fail_d = 1'b1;
               if (!fail_q) begin
                  fail_addr_d = count;
                  fail_elem_d = elem_q;
               end
            end
            // E5 has no write, so CMP is the last step of its address
            if (mismatch && STOP_ON_FAIL) begin
               state_d = ST_DONE;
            end else if (elem_has_wr(elem_q)) begin
               state_d = ST_WR;
            end else if (carry) begin
               state_d = ST_DONE;
            end else begin
               cnt_en  = 1'b1;
               state_d = ST_RD;
            end
         end
         ST_WR: begin
            mem_we = 1'b1;
            if (carry) begin
               elem_d     = elem_nxt;
               cnt_reset  = elem_up(elem_nxt);
               cnt_preset = !elem_up(elem_nxt);
               state_d    = elem_has_rd(elem_nxt) ? ST_RD : ST_WR;
            end else begin
               cnt_en  = 1'b1;
               state_d = elem_has_rd(elem_q) ? ST_RD : ST_WR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         elem_q      <= E0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   assign bus.mem_addr  = count;
   assign bus.mem_re    = mem_re;
   assign bus.mem_we    = mem_we;
   assign bus.mem_wdata = (mem_we && elem_wr_val(elem_q)) ? '1 : '0;
   assign bus.busy      = (state_q == ST_RD) || (state_q == ST_CMP) || (state_q == ST_WR);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.fail      = fail_q;
   assign bus.fail_addr = fail_addr_q;
   assign bus.fail_elem = fail_elem_q;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: two instances (stop-on-fail and run-to-end) on faulty RAM models,
// table-driven runs plus a mid-test reset sequence.
module tb_bist_march_ctrl;

   logic clk;
   logic rst;

   bist_march_ctrl_if #(.ADDR_W(4), .DATA_W(8)) ifs ();
   bist_march_ctrl_if #(.ADDR_W(4), .DATA_W(8)) ifc ();

   bist_march_ctrl #(.ADDR_W(4), .DATA_W(8), .STOP_ON_FAIL(1'b1)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (ifs)
   );

   bist_march_ctrl #(.ADDR_W(4), .DATA_W(8), .STOP_ON_FAIL(1'b0)) dut_c (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_chk  = 0;
   int   n_fail = 0;

   bit   f_en   = 1'b0;
   int   f_addr = 0;
   int   f_bit  = 0;
   bit   f_val  = 1'b0;

   logic [7:0] mem_s [16];
   logic [7:0] mem_c [16];

   function automatic logic [7:0] rd_fault(input logic [7:0] d, input logic [3:0] a);
      logic [7:0] r;
      r = d;
      if (f_en && (a == f_addr[3:0])) r[f_bit] = f_val;
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (ifs.mem_we) mem_s[ifs.mem_addr] <= ifs.mem_wdata;
      if (ifs.mem_re) ifs.mem_rdata <= rd_fault(mem_s[ifs.mem_addr], ifs.mem_addr);
      if (ifc.mem_we) mem_c[ifc.mem_addr] <= ifc.mem_wdata;
      if (ifc.mem_re) ifc.mem_rdata <= rd_fault(mem_c[ifc.mem_addr], ifc.mem_addr);
   end

   // sel=1 looks at the stop-on-fail instance, sel=0 at the run-to-end one
   bit         sel = 1'b1;
   logic       cur_busy, cur_done, cur_fail, cur_re, cur_we;
   logic [3:0] cur_addr, cur_faddr;
   logic [2:0] cur_felem;
   logic [7:0] cur_wd;

   assign cur_busy  = sel ? ifs.busy      : ifc.busy;
   assign cur_done  = sel ? ifs.done      : ifc.done;
   assign cur_fail  = sel ? ifs.fail      : ifc.fail;
   assign cur_re    = sel ? ifs.mem_re    : ifc.mem_re;
   assign cur_we    = sel ? ifs.mem_we    : ifc.mem_we;
   assign cur_addr  = sel ? ifs.mem_addr  : ifc.mem_addr;
   assign cur_faddr = sel ? ifs.fail_addr : ifc.fail_addr;
   assign cur_felem = sel ? ifs.fail_elem : ifc.fail_elem;
   assign cur_wd    = sel ? ifs.mem_wdata : ifc.mem_wdata;

   typedef struct {
      bit sel;
      bit f_en;
      int f_addr;
      int f_bit;
      bit f_val;
      int restart;
      int cycles;
      bit fail;
      int faddr;
      int felem;
      int we_fa;
   } row_t;

   row_t        rows [7];
   logic [13:0] exp_trace [240];

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_start(input bit v);
      if (sel) ifs.start = v;
      else     ifc.start = v;
   endtask

   task automatic run_row(input row_t r);
      int cyc;
      int we_fa;
      sel    = r.sel;
      f_en   = r.f_en;
      f_addr = r.f_addr;
      f_bit  = r.f_bit;
      f_val  = r.f_val;
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      check("flags_cleared_on_start", {cur_done, cur_fail}, 2'b00);
      cyc   = 0;
      we_fa = 0;
      while (cur_busy && cyc < 300) begin
         drive_start(cyc == r.restart);
         if (cyc < 240)
            check($sformatf("trace[%0d]", cyc),
                  {cur_addr, cur_re, cur_we, (cur_we ? cur_wd : 8'h00)}, exp_trace[cyc]);
         if (cur_we && (cur_addr == r.f_addr[3:0])) we_fa++;
         cyc++;
         @(negedge clk);
      end
      drive_start(1'b0);
      check("busy_cycles", cyc, r.cycles);
      check("done", cur_done, 1);
      check("fail", cur_fail, r.fail);
      check("fail_addr", cur_faddr, r.faddr);
      check("fail_elem", cur_felem, r.felem);
      check("writes_at_fault_addr", we_fa, r.we_fa);
      repeat (2) @(negedge clk);
      check("done_holds", {cur_busy, cur_done}, 2'b01);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         k;
      logic [3:0] a;

      k = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < 16; i++) begin
            a = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
            if (e != 0) begin
               exp_trace[k] = {a, 1'b1, 1'b0, 8'h00}; k++;
               exp_trace[k] = {a, 1'b0, 1'b0, 8'h00}; k++;
            end
            if (e != 5) begin
               exp_trace[k] = {a, 1'b0, 1'b1, ((e == 1 || e == 3) ? 8'hFF : 8'h00)}; k++;
            end
         end
      end

      //          sel f_en addr bit val restart cycles fail faddr felem we_fa
      rows[0] = '{1'b1, 1'b0,  5, 2, 1'b1, -1, 240, 1'b0,  0, 0, 5};
      rows[1] = '{1'b1, 1'b1,  5, 2, 1'b1, -1,  33, 1'b1,  5, 1, 1};
      rows[2] = '{1'b1, 1'b0,  5, 2, 1'b1, 30, 240, 1'b0,  0, 0, 5};
      rows[3] = '{1'b0, 1'b1,  5, 2, 1'b1, -1, 240, 1'b1,  5, 1, 5};
      rows[4] = '{1'b1, 1'b1, 15, 0, 1'b0, -1, 111, 1'b1, 15, 2, 2};
      rows[5] = '{1'b0, 1'b1, 15, 0, 1'b0, 40, 240, 1'b1, 15, 2, 5};
      rows[6] = '{1'b0, 1'b0,  0, 0, 1'b0, -1, 240, 1'b0,  0, 0, 5};

      rst       = 1'b1;
      ifs.start = 1'b0;
      ifc.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs_s", {ifs.busy, ifs.done, ifs.fail, ifs.fail_addr, ifs.fail_elem,
                                ifs.mem_re, ifs.mem_we, ifs.mem_addr, ifs.mem_wdata}, 0);
      check("reset_outputs_c", {ifc.busy, ifc.done, ifc.fail, ifc.fail_addr, ifc.fail_elem,
                                ifc.mem_re, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata}, 0);
      repeat (5) @(negedge clk);

      for (int i = 0; i < 6; i++) run_row(rows[i]);

      // reset while E2 is reading address 7
      sel  = 1'b0;
      f_en = 1'b0;
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      repeat (85) @(negedge clk);
      check("pre_reset_e2_addr7", {cur_addr, cur_re, cur_busy}, {4'd7, 1'b1, 1'b1});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_reset_outputs", {ifc.busy, ifc.done, ifc.fail, ifc.fail_addr, ifc.fail_elem,
                                     ifc.mem_re, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata}, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_after_reset", {ifc.busy, ifc.mem_re, ifc.mem_we}, 0);
      end
      run_row(rows[6]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
